// File: rtl/fft_pair_seq.sv
// Radix-2 DIT butterfly address sequencer: streams (a, b, twiddle, stage) tuples
// over a valid/ready port for one stage or all LOG2 stages of a SAMPLES-point FFT.

module fft_pair_addr #(
  parameter int SAMPLES = 8,
  parameter int LOG2    = $clog2(SAMPLES)
) (
  input  logic [LOG2-2:0] p_i,
  input  logic [LOG2-1:0] s_i,
  output logic [LOG2-1:0] a_o,
  output logic [LOG2-1:0] b_o,
  output logic [LOG2-2:0] tw_o
);
  logic [LOG2-1:0] p_ext, mask, j, g, tw_full;
  logic [31:0]     tw_sh;

  always_comb begin
    p_ext   = {1'b0, p_i};
    mask    = (LOG2'(1) << s_i) - LOG2'(1);
    j       = p_ext & mask;
    g       = p_ext >> s_i;
    a_o     = (g << (s_i + LOG2'(1))) | j;
    b_o     = a_o + (LOG2'(1) << s_i);
    // j * (SAMPLES >> (s+1)) is a left shift by LOG2-1-s; s is always a legal stage here
    tw_sh   = 32'(LOG2 - 1) - 32'(s_i);
    tw_full = j << tw_sh;
    tw_o    = tw_full[LOG2-2:0];
  end
endmodule

module fft_pair_seq #(
  parameter int SAMPLES = 8,
  parameter int LOG2    = $clog2(SAMPLES)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            all_stages_i,
  input  logic [LOG2-1:0] stage_in_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [LOG2-1:0] addr_a_o,
  output logic [LOG2-1:0] addr_b_o,
  output logic [LOG2-2:0] twiddle_o,
  output logic [LOG2-1:0] stage_o,
  output logic            last_in_stage_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  localparam int HALF = SAMPLES / 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [LOG2-1:0] a;
    logic [LOG2-1:0] b;
    logic [LOG2-2:0] tw;
    logic [LOG2-1:0] stage;
    logic            last;
  } bfly_t;

  state_t          state_q, state_d;
  logic [LOG2-2:0] p_q, p_d;
  logic [LOG2-1:0] s_q, s_d;
  logic            all_q, all_d;
  logic            err_q, err_d;
  bfly_t           bfly_q, bfly_d;

  logic [LOG2-1:0] nxt_a, nxt_b;
  logic [LOG2-2:0] nxt_tw;
  logic            p_last;

  assign p_last = (p_q == (LOG2-1)'(HALF - 1));

  // Fields are computed from the next-state counters so the output register
  // always holds the butterfly for the pair counter it is about to present.
  fft_pair_addr #(.SAMPLES(SAMPLES), .LOG2(LOG2)) u_addr (
    .p_i  (p_d),
    .s_i  (s_d),
    .a_o  (nxt_a),
    .b_o  (nxt_b),
    .tw_o (nxt_tw)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    all_d   = all_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!all_stages_i && (32'(stage_in_i) >= 32'(LOG2))) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            p_d     = '0;
            s_d     = all_stages_i ? '0 : stage_in_i;
            all_d   = all_stages_i;
          end
        end
      end
      RUN: begin
        if (out_ready_i) begin
          if (p_last) begin
            p_d = '0;
            if (all_q && (s_q != LOG2'(LOG2 - 1))) s_d = s_q + LOG2'(1);
            else                                   state_d = DONE;
          end else begin
            p_d = p_q + (LOG2-1)'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bfly_d = '0;
    if (state_d == RUN) begin
      bfly_d.a     = nxt_a;
      bfly_d.b     = nxt_b;
      bfly_d.tw    = nxt_tw;
      bfly_d.stage = s_d;
      bfly_d.last  = (p_d == (LOG2-1)'(HALF - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      all_q   <= all_d;
      err_q   <= err_d;
      bfly_q  <= bfly_d;
    end
  end

  assign out_valid_o     = (state_q == RUN);
  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign err_o           = err_q;
  assign addr_a_o        = bfly_q.a;
  assign addr_b_o        = bfly_q.b;
  assign twiddle_o       = bfly_q.tw;
  assign stage_o         = bfly_q.stage;
  assign last_in_stage_o = bfly_q.last;
endmodule

// File: tb/tb_fft_pair_seq.sv
// Directed bench for fft_pair_seq: SAMPLES=8 and SAMPLES=16 instances on one clock.

module tb_fft_pair_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st8, all8, rdy8, vld8, last8, busy8, done8, err8;
  logic [2:0] sin8, a8, b8, stg8;
  logic [1:0] tw8;

  logic       st16, all16, rdy16, vld16, last16, busy16, done16, err16;
  logic [3:0] sin16, a16, b16, stg16;
  logic [2:0] tw16;

  int total = 0;
  int passed = 0;
  int idx;

  int ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int sa[4]  = '{0, 1, 4, 5};
  int sb[4]  = '{2, 3, 6, 7};
  int st[4]  = '{0, 2, 0, 2};

  fft_pair_seq #(.SAMPLES(8)) dut8 (
    .clk_i(clk), .reset_i(rst), .start_i(st8), .all_stages_i(all8),
    .stage_in_i(sin8), .out_ready_i(rdy8), .out_valid_o(vld8),
    .addr_a_o(a8), .addr_b_o(b8), .twiddle_o(tw8), .stage_o(stg8),
    .last_in_stage_o(last8), .busy_o(busy8), .done_o(done8), .err_o(err8)
  );

  fft_pair_seq #(.SAMPLES(16)) dut16 (
    .clk_i(clk), .reset_i(rst), .start_i(st16), .all_stages_i(all16),
    .stage_in_i(sin16), .out_ready_i(rdy16), .out_valid_o(vld16),
    .addr_a_o(a16), .addr_b_o(b16), .twiddle_o(tw16), .stage_o(stg16),
    .last_in_stage_o(last16), .busy_o(busy16), .done_o(done16), .err_o(err16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    st8 = 0; all8 = 0; sin8 = 0; rdy8 = 0;
    st16 = 0; all16 = 0; sin16 = 0; rdy16 = 0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_valid", vld8, 0);  chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);  chk("rst_err", err8, 0);
    chk("rst_a", a8, 0);        chk("rst_b", b8, 0);
    chk("rst_tw", tw8, 0);      chk("rst_stage", stg8, 0);
    chk("rst_last", last8, 0);  chk("rst_valid16", vld16, 0);
    rst = 1'b0;
    @(negedge clk);

    // reset the cycle after start aborts without done
    st8 = 1; all8 = 1; rdy8 = 0;
    @(negedge clk);
    st8 = 0;
    chk("abort_pre_valid", vld8, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", vld8, 0); chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0); chk("abort_a", a8, 0); chk("abort_b", b8, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_idle_valid", vld8, 0);
      chk("abort_idle_done", done8, 0);
    end

    // all-stage run, start held high throughout (must be ignored in RUN/DONE)
    st8 = 1; all8 = 1; rdy8 = 1;
    @(negedge clk);
    all8 = 0; sin8 = 3'd1;
    for (int i = 0; i < 12; i++) begin
      chk("full_valid", vld8, 1);
      chk("full_busy", busy8, 1);
      chk("full_a", a8, ea[i]);
      chk("full_b", b8, eb[i]);
      chk("full_tw", tw8, et[i]);
      chk("full_stage", stg8, i / 4);
      chk("full_last", last8, (i % 4) == 3);
      chk("full_nodone", done8, 0);
      @(negedge clk);
    end
    chk("full_done", done8, 1);
    chk("full_done_valid", vld8, 0);
    chk("full_done_busy", busy8, 0);
    @(negedge clk);
    st8 = 0;
    chk("full_done_clear", done8, 0);
    chk("full_no_restart", vld8, 0);
    chk("full_no_err", err8, 0);
    @(negedge clk);
    chk("full_idle_valid", vld8, 0);
    chk("full_idle_done", done8, 0);

    // rejected start
    st8 = 1; all8 = 0; sin8 = 3'd3;
    @(negedge clk);
    st8 = 0;
    chk("err_pulse", err8, 1); chk("err_busy", busy8, 0); chk("err_valid", vld8, 0);
    @(negedge clk);
    chk("err_clear", err8, 0); chk("err_valid2", vld8, 0); chk("err_busy2", busy8, 0);

    // single stage 1 with out_ready 1,0,0,1,...
    st8 = 1; all8 = 0; sin8 = 3'd1; rdy8 = 0;
    @(negedge clk);
    st8 = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      chk("single_valid", vld8, 1);
      chk("single_a", a8, sa[idx]);
      chk("single_b", b8, sb[idx]);
      chk("single_tw", tw8, st[idx]);
      chk("single_stage", stg8, 1);
      chk("single_last", last8, idx == 3);
      chk("single_nodone", done8, 0);
      rdy8 = ((c % 3) == 0);
      @(negedge clk);
      if (rdy8) idx++;
    end
    chk("single_xfers", idx, 4);
    rdy8 = 0;
    chk("single_done", done8, 1);
    chk("single_done_valid", vld8, 0);
    @(negedge clk);
    chk("single_done_clear", done8, 0);

    // SAMPLES=16 all stages
    st16 = 1; all16 = 1; rdy16 = 1;
    @(negedge clk);
    st16 = 0;
    for (int i = 0; i < 32; i++) begin
      chk("s16_valid", vld16, 1);
      chk("s16_stage", stg16, i / 8);
      chk("s16_last", last16, (i % 8) == 7);
      if (i >= 16 && i < 24) chk("s16_st2_tw", tw16, ((i - 16) % 4) * 2);
      if (i >= 24) begin
        chk("s16_st3_a", a16, i - 24);
        chk("s16_st3_b", b16, i - 16);
        chk("s16_st3_tw", tw16, i - 24);
      end
      @(negedge clk);
    end
    chk("s16_done", done16, 1);
    chk("s16_done_valid", vld16, 0);
    @(negedge clk);
    chk("s16_done_clear", done16, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fft_pair_seq.md
# fft_pair_seq

Sequential radix-2 butterfly address sequencer for a SAMPLES-point in-place DIT FFT. It streams one butterfly per accepted handshake, each carrying the sample index pair (a, b), a twiddle index and stage tags. It generalises the fixed single-stage index table into a clocked generator with a valid/ready output, single-stage or all-stage runs, and completion signalling. It sits between the FFT control FSM and the sample-memory/butterfly datapath.

## Interface
- SAMPLES, 8, FFT length; power of two, ≥ 4. LOG2 = $clog2(SAMPLES).
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  **one clock; reset is synchronous and active-high**.
- start  in  1  request a run; sampled only in IDLE.
- all_stages  in  1  with start: 1 = run stages 0..LOG2-1; 0 = run only stage_in.
- stage_in  in  LOG2  stage for single-stage runs; ignored when all_stages=1.
- out_ready  in  1  consumer accepts the current butterfly.
- out_valid  out  1  butterfly fields valid.
- addr_a  out  LOG2  lower sample index.
- addr_b  out  LOG2  upper sample index, = addr_a + 2^stage.
- twiddle  out  LOG2-1  twiddle exponent k for W_SAMPLES^k.
- stage  out  LOG2  stage of the current butterfly.
- last_in_stage  out  1  current butterfly is the final one of its stage.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final butterfly is accepted.
- err  out  1  one-cycle pulse on a rejected start.

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE -> RUN on start=1 with a legal request. Load stage to 0 (all_stages) or stage_in (single). Clear pair counter p (LOG2-1 bits).
- Rejected start: all_stages=0 and stage_in ≥ LOG2. Pulse err next cycle and stay in IDLE.
- Butterfly p of stage s, with j = p mod 2^s and g = p >> s:
  - addr_a = (g << (s+1)) | j
  - addr_b = addr_a + 2^s
  - twiddle = j · (SAMPLES >> (s+1)), truncated to LOG2-1 bits.
- Ordering: j increments fastest within group g, then g. SAMPLES/2 butterflies per stage.
- Handshake: a transfer occurs on a cycle with out_valid & out_ready.
  - On transfer, p increments.
  - When p = SAMPLES/2-1 (last_in_stage=1), p wraps to 0. Stage increments if all_stages=1 and stage < LOG2-1; otherwise go to DONE.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE and RUN.
- Arithmetic is unsigned. addr_b never overflows LOG2 bits by construction.

## Timing
- Reset values: out_valid=0, busy=0, done=0, err=0, addr_a=0, addr_b=0, twiddle=0, stage=0, last_in_stage=0. State is IDLE, p=0.
- Reset has priority over every other input. Asserting it mid-RUN aborts with no done pulse; outputs return to reset values on the next edge.
- Latency: start accepted at edge N -> out_valid=1 with first butterfly from edge N+1. busy is high from the same edge.
- Throughput: one butterfly per cycle when out_ready is held high. There is no bubble between stages.
- Outputs are registered. out_valid is not combinationally dependent on out_ready.
- Final transfer at edge M:
  - Edge M+1: out_valid=0, busy=0, done=1.
  - Edge M+2: done=0, state IDLE, start sampled again from here.
- A full run takes (SAMPLES/2)·LOG2 transfers; a single-stage run takes SAMPLES/2.
- Rejected start at edge N: err=1 during cycle N+1 only.

## Test plan
- Reset, SAMPLES=8: check all outputs at reset values. Then assert reset on the cycle after start -> no out_valid, no done.
- SAMPLES=8, all_stages=1, out_ready=1 -> 12 consecutive butterflies, (a,b,twiddle) in order:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - last_in_stage on the 4th, 8th and 12th; done one cycle after the 12th.
- SAMPLES=8, single stage_in=1, out_ready toggling 1,0,0,1,… -> pairs (0,2),(1,3),(4,6),(5,7); outputs stable during stalls; done after the 4th transfer.
- SAMPLES=8, start with all_stages=0, stage_in=3 -> err pulse one cycle, busy stays 0, no out_valid.
- start asserted during RUN and on the DONE cycle -> ignored; the sequence is unaltered and only one done pulse occurs.
- SAMPLES=16, all_stages=1 -> 32 transfers. Stage 3 pairs (k, k+8) with twiddle k for k=0..7. Stage 2 twiddles 0,2,4,6 repeating.
